// File: rtl/inst_mem_loader_if.sv
// inst_mem_loader_if: UART byte input and instruction-memory debug write bus of the loader
interface inst_mem_loader_if;
  logic        in_start;
  logic [7:0]  in_rx_data;
  logic        in_rx_done;
  logic [31:0] out_ins_to_mem;
  logic        out_wea_ram_inst;
  logic [31:0] out_addr_debug;
  logic        out_debug_flag;
  logic        out_load_done;
  logic        out_overflow;
  logic [31:0] out_word_count;
  logic [31:0] out_checksum;
  modport master (
    output in_start, in_rx_data, in_rx_done,
    input  out_ins_to_mem, out_wea_ram_inst, out_addr_debug, out_debug_flag,
    input  out_load_done, out_overflow, out_word_count, out_checksum
  );
  modport slave (
    input  in_start, in_rx_data, in_rx_done,
    output out_ins_to_mem, out_wea_ram_inst, out_addr_debug, out_debug_flag,
    output out_load_done, out_overflow, out_word_count, out_checksum
  );
endinterface

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: assembles UART bytes into words and writes them to instruction memory; LOADER_CHECKSUM_EN adds an XOR checksum of written words
module inst_mem_loader #(
  parameter int          MEM_DEPTH = 2048,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input logic            clk,
  input logic            reset,
  inst_mem_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;
  localparam logic [31:0] LAST_ADDR = 32'(MEM_DEPTH - 1);
  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] word_q, word_d;
  logic [31:0] ins_q, ins_d;
  logic        wea_q, wea_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] count_q, count_d;
  logic        ovf_q, ovf_d;
  logic        clear;
  assign clear = state_q == IDLE || (state_q == DONE && bus.in_start);
  // next state: byte assembly, one-cycle write pulse, and address/count advance as the pulse falls
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    ins_d      = ins_q;
    wea_d      = 1'b0;
    addr_d     = addr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    if (state_q != RECV) begin
      if (clear) begin
        addr_d     = '0;
        byte_cnt_d = '0;
        count_d    = '0;
        ovf_d      = 1'b0;
      end
      state_d = bus.in_start ? RECV : state_q;
    end else begin
      if (bus.in_rx_done) begin
        word_d     = {word_q[15:0], bus.in_rx_data};
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) begin
          ins_d = {word_q, bus.in_rx_data};
          wea_d = 1'b1;
        end
      end
      if (wea_q) begin
        addr_d  = addr_q + 32'd1;
        count_d = count_q + 32'd1;
        if (ins_q == HALT_WORD || addr_q == LAST_ADDR) begin
          state_d = DONE;
          ovf_d   = ins_q != HALT_WORD;
        end
      end
    end
  end
  // state registers; reset drops partial bytes and any pending write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      word_q     <= '0;
      ins_q      <= '0;
      wea_q      <= 1'b0;
      addr_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      ins_q      <= ins_d;
      wea_q      <= wea_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;
  // checksum folds in each word as its write completes
  always_comb begin
    csum_d = clear ? '0 : (state_q == RECV && wea_q) ? csum_q ^ ins_q : csum_q;
  end
  // checksum register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) csum_q <= '0;
    else csum_q <= csum_d;
  end
  assign bus.out_checksum = csum_q;
`else
  assign bus.out_checksum = '0;
`endif
  assign bus.out_ins_to_mem   = ins_q;
  assign bus.out_wea_ram_inst = wea_q;
  assign bus.out_addr_debug   = addr_q;
  assign bus.out_debug_flag   = state_q == RECV;
  assign bus.out_load_done    = state_q == DONE;
  assign bus.out_overflow     = ovf_q;
  assign bus.out_word_count   = count_q;
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: directed byte streams into two loaders (depth 2048 and 4) checked against a write-list model
module tb_inst_mem_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic rxdone = 1'b0;
  logic [7:0] rxd = '0;
  int nvec = 0;
  int nerr = 0;
  always #5 clk = ~clk;
  inst_mem_loader_if ifa ();
  inst_mem_loader_if ifb ();
  assign ifa.in_start = start;
  assign ifa.in_rx_done = rxdone;
  assign ifa.in_rx_data = rxd;
  assign ifb.in_start = start;
  assign ifb.in_rx_done = rxdone;
  assign ifb.in_rx_data = rxd;
  inst_mem_loader #(.MEM_DEPTH(2048)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  inst_mem_loader #(.MEM_DEPTH(4))    dut_b (.clk(clk), .reset(reset), .bus(ifb));
  logic [31:0] o_ins[2], o_addr[2], o_cnt[2], o_cs[2];
  logic        o_wea[2], o_dbg[2], o_done[2], o_ovf[2];
  assign o_ins[0] = ifa.out_ins_to_mem;   assign o_ins[1] = ifb.out_ins_to_mem;
  assign o_addr[0] = ifa.out_addr_debug;  assign o_addr[1] = ifb.out_addr_debug;
  assign o_cnt[0] = ifa.out_word_count;   assign o_cnt[1] = ifb.out_word_count;
  assign o_cs[0] = ifa.out_checksum;      assign o_cs[1] = ifb.out_checksum;
  assign o_wea[0] = ifa.out_wea_ram_inst; assign o_wea[1] = ifb.out_wea_ram_inst;
  assign o_dbg[0] = ifa.out_debug_flag;   assign o_dbg[1] = ifb.out_debug_flag;
  assign o_done[0] = ifa.out_load_done;   assign o_done[1] = ifb.out_load_done;
  assign o_ovf[0] = ifa.out_overflow;     assign o_ovf[1] = ifb.out_overflow;
  int          depth[2] = '{2048, 4};
  logic        m_load[2], m_done[2], m_ovf[2], m_pend[2];
  logic [31:0] m_addr[2], m_cnt[2], m_csum[2], m_pdata[2], m_word[2];
  int          m_n[2];
  logic [31:0] lg_addr[2][32], lg_data[2][32];
  int          lg_n[2] = '{0, 0};
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  function automatic logic [31:0] exp_cs(input logic [31:0] v);
`ifdef LOADER_CHECKSUM_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        chk("rst_wea", {31'b0, o_wea[i]}, 0);
        chk("rst_ins", o_ins[i], 0);
        chk("rst_addr", o_addr[i], 0);
        chk("rst_flags", {28'b0, o_dbg[i], o_done[i], o_ovf[i], 1'b0}, 0);
        chk("rst_cnt", o_cnt[i], 0);
        chk("rst_cs", o_cs[i], 0);
        m_load[i] = 0; m_done[i] = 0; m_ovf[i] = 0; m_pend[i] = 0;
        m_addr[i] = 0; m_cnt[i] = 0; m_csum[i] = 0; m_word[i] = 0; m_n[i] = 0;
      end else begin
        logic old_load;
        logic [31:0] la;
        chk($sformatf("wea%0d", i), {31'b0, o_wea[i]}, {31'b0, m_pend[i]});
        if (m_pend[i]) chk($sformatf("ins%0d", i), o_ins[i], m_pdata[i]);
        chk($sformatf("addr%0d", i), o_addr[i], m_addr[i]);
        chk($sformatf("cnt%0d", i), o_cnt[i], m_cnt[i]);
        chk($sformatf("dbg%0d", i), {31'b0, o_dbg[i]}, {31'b0, m_load[i]});
        chk($sformatf("done%0d", i), {31'b0, o_done[i]}, {31'b0, m_done[i]});
        chk($sformatf("ovf%0d", i), {31'b0, o_ovf[i]}, {31'b0, m_ovf[i]});
        chk($sformatf("cs%0d", i), o_cs[i], exp_cs(m_csum[i]));
        if (o_wea[i] && lg_n[i] < 32) begin
          lg_addr[i][lg_n[i]] = o_addr[i];
          lg_data[i][lg_n[i]] = o_ins[i];
          lg_n[i]++;
        end
        old_load = m_load[i];
        if (m_pend[i]) begin
          la = m_addr[i];
          m_pend[i] = 0;
          m_addr[i]++;
          m_cnt[i]++;
          m_csum[i] ^= m_pdata[i];
          if (m_pdata[i] == 32'hFFFFFFFF || la == 32'(depth[i] - 1)) begin
            m_load[i] = 0;
            m_done[i] = 1;
            m_ovf[i] = m_pdata[i] != 32'hFFFFFFFF;
          end
        end
        if (!old_load && start) begin
          m_load[i] = 1; m_done[i] = 0; m_ovf[i] = 0;
          m_addr[i] = 0; m_cnt[i] = 0; m_csum[i] = 0; m_n[i] = 0;
        end
        if (old_load && rxdone) begin
          m_word[i] = {m_word[i][23:0], rxd};
          m_n[i]++;
          if (m_n[i] == 4) begin
            m_n[i] = 0;
            m_pend[i] = 1;
            m_pdata[i] = m_word[i];
          end
        end
      end
    end
  end
  task automatic drive(input logic s, input logic dn, input logic [7:0] d);
    start = s; rxdone = dn; rxd = d;
    @(posedge clk); #1;
    start = 0; rxdone = 0;
  endtask
  task automatic send(input logic [7:0] b);
    drive(0, 1, b);
  endtask
  task automatic idle(input int n);
    repeat (n) drive(0, 0, 8'h00);
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send(w[8*k +: 8]);
  endtask
  initial begin
    int base;
    logic [7:0] s1[8] = '{8'hAC, 8'h03, 8'h00, 8'h00, 8'hAC, 8'h03, 8'h33, 8'h33};
    repeat (3) @(posedge clk);
    #1 reset = 0;
    idle(2);
    send(8'h55); send(8'hAA); idle(2);
    chk("idle_bytes_no_write", lg_n[0], 0);
    base = lg_n[0];
    drive(1, 0, 0);
    for (int k = 0; k < 6; k++) send(s1[k]);
    drive(1, 0, 0);
    send(s1[6]); send(s1[7]);
    idle(1);
    send_word(32'hFFFFFFFF);
    idle(4);
    chk("t1_nwrites", lg_n[0] - base, 3);
    chk("t1_w0", lg_data[0][base], 32'hAC030000);
    chk("t1_a0", lg_addr[0][base], 0);
    chk("t1_w1", lg_data[0][base+1], 32'hAC033333);
    chk("t1_a1", lg_addr[0][base+1], 1);
    chk("t1_w2", lg_data[0][base+2], 32'hFFFFFFFF);
    chk("t1_a2", lg_addr[0][base+2], 2);
    chk("t1_done", {31'b0, o_done[0]}, 1);
    chk("t1_cnt", o_cnt[0], 3);
    chk("t1_ovf", {31'b0, o_ovf[0]}, 0);
    chk("t1_dbg", {31'b0, o_dbg[0]}, 0);
`ifdef LOADER_CHECKSUM_EN
    chk("t1_cs", o_cs[0], 32'hFFFFCCCC);
`else
    chk("t1_cs", o_cs[0], 32'h0);
`endif
    base = lg_n[0];
    send_word(32'h11111111); idle(3);
    chk("done_bytes_no_write", lg_n[0] - base, 0);
    chk("done_addr_held", o_addr[0], 3);
    base = lg_n[1];
    drive(1, 0, 0);
    send_word(32'h01020304); idle(1);
    send_word(32'h05060708); idle(1);
    send_word(32'h090A0B0C); idle(1);
    send_word(32'h0D0E0F10); idle(3);
    chk("ovf_nwrites", lg_n[1] - base, 4);
    chk("ovf_last_addr", lg_addr[1][base+3], 3);
    chk("ovf_last_word", lg_data[1][base+3], 32'h0D0E0F10);
    chk("ovf_flags", {29'b0, o_done[1], o_ovf[1], o_dbg[1]}, 32'b110);
    chk("ovf_cnt", o_cnt[1], 4);
    chk("ovf_addr", o_addr[1], 4);
    chk("deep_still_loading", {31'b0, o_dbg[0]}, 1);
    chk("deep_cnt", o_cnt[0], 4);
    base = lg_n[0];
    send(8'h21); send(8'h22);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    idle(1);
    chk("rst_no_write", lg_n[0] - base, 0);
    drive(1, 0, 0);
    send_word(32'h12345678); idle(3);
    chk("rst_nwrites", lg_n[0] - base, 1);
    chk("rst_word", lg_data[0][base], 32'h12345678);
    chk("rst_addr0", lg_addr[0][base], 0);
    chk("rst_cnt1", o_cnt[0], 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
